// File: rtl/fetch_unit_if.sv
// Program-memory read port of the fetch stage: request/address out, ack/data back.
interface fetch_unit_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int WORD_WIDTH = 16
);
  logic                  mem_req;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_ack;
  logic [WORD_WIDTH-1:0] mem_rdata;

  modport master (output mem_req, mem_addr, input mem_ack, mem_rdata);
  modport slave  (input mem_req, mem_addr, output mem_ack, mem_rdata);
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, reads program memory, decodes IR fields.
// Optional abort of stalled reads is enabled with `define FETCH_TIMEOUT_EN.
//
// state | meaning
// IDLE  | no read outstanding; IR and instr_valid hold the last result
// WAIT  | read issued, mem_req held until mem_ack (or timeout abort)
module fetch_unit #(
  parameter int ADDR_WIDTH     = 8,
  parameter int WORD_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fetch_go,
  input  logic                  pc_next,
  input  logic                  pc_load,
  input  logic [ADDR_WIDTH-1:0] pc_target,
  fetch_unit_if.master          mem,
  output logic                  busy,
  output logic                  instr_valid,
  output logic [3:0]            opcode,
  output logic [3:0]            reg_a,
  output logic [3:0]            reg_b,
  output logic [3:0]            reg_c,
  output logic [7:0]            big_val,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic                  fetch_err
);

  if (WORD_WIDTH != 16 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("fetch_unit: field layout needs WORD_WIDTH=16 and TIMEOUT_CYCLES>=1");
  end

  typedef enum logic {IDLE, WAIT} state_t;

  state_t                state_q, state_nxt;
  logic                  req_q, req_nxt;
  logic [ADDR_WIDTH-1:0] addr_q, addr_nxt;
  logic                  busy_q, busy_nxt;
  logic                  valid_q, valid_nxt;
  logic [WORD_WIDTH-1:0] ir_q, ir_nxt;
  logic [ADDR_WIDTH-1:0] pc_q, pc_nxt;

`ifdef FETCH_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);
  logic [CW-1:0] cnt_q, cnt_nxt;
  logic          err_q, err_nxt;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      addr_q  <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      ir_q    <= '0;
      pc_q    <= '0;
`ifdef FETCH_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_nxt;
      req_q   <= req_nxt;
      addr_q  <= addr_nxt;
      busy_q  <= busy_nxt;
      valid_q <= valid_nxt;
      ir_q    <= ir_nxt;
      pc_q    <= pc_nxt;
`ifdef FETCH_TIMEOUT_EN
      cnt_q   <= cnt_nxt;
      err_q   <= err_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt = state_q;
    req_nxt   = req_q;
    addr_nxt  = addr_q;
    busy_nxt  = busy_q;
    valid_nxt = valid_q;
    ir_nxt    = ir_q;
`ifdef FETCH_TIMEOUT_EN
    cnt_nxt   = cnt_q;
    err_nxt   = err_q;
`endif
    case (state_q)
      IDLE: begin
        // Address is captured from the pre-update PC, so a same-edge jump cannot disturb it.
        if (fetch_go) begin
          addr_nxt  = pc_q;
          req_nxt   = 1'b1;
          busy_nxt  = 1'b1;
          valid_nxt = 1'b0;
          state_nxt = WAIT;
`ifdef FETCH_TIMEOUT_EN
          cnt_nxt   = '0;
          err_nxt   = 1'b0;
`endif
        end
      end
      WAIT: begin
        if (mem.mem_ack) begin
          ir_nxt    = mem.mem_rdata;
          valid_nxt = 1'b1;
          req_nxt   = 1'b0;
          busy_nxt  = 1'b0;
          state_nxt = IDLE;
        end
`ifdef FETCH_TIMEOUT_EN
        else if (cnt_q == TMO_LAST) begin
          req_nxt   = 1'b0;
          busy_nxt  = 1'b0;
          err_nxt   = 1'b1;
          state_nxt = IDLE;
        end else begin
          cnt_nxt   = cnt_q + 1'b1;
        end
`endif
      end
      default: state_nxt = IDLE;
    endcase

    if (pc_load)      pc_nxt = pc_target;
    else if (pc_next) pc_nxt = pc_q + 1'b1;
    else              pc_nxt = pc_q;
  end

  assign mem.mem_req  = req_q;
  assign mem.mem_addr = addr_q;
  assign busy         = busy_q;
  assign instr_valid  = valid_q;
  assign pc           = pc_q;
  assign opcode       = ir_q[15:12];
  assign reg_a        = ir_q[11:8];
  assign reg_b        = ir_q[7:4];
  assign reg_c        = ir_q[3:0];
  assign big_val      = ir_q[7:0];

`ifdef FETCH_TIMEOUT_EN
  assign fetch_err = err_q;
`else
  assign fetch_err = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: vector table plus reset-in-WAIT and stall sequences.
module tb_fetch_unit;
  logic       clk = 1'b0;
  logic       reset;
  logic       fetch_go, pc_next, pc_load;
  logic [7:0] pc_target;
  logic       busy, instr_valid, fetch_err;
  logic [3:0] opcode, reg_a, reg_b, reg_c;
  logic [7:0] big_val, pc;

  int total = 0;
  int bad   = 0;

  fetch_unit_if #(.ADDR_WIDTH(8), .WORD_WIDTH(16)) bus ();

  fetch_unit #(.ADDR_WIDTH(8), .WORD_WIDTH(16), .TIMEOUT_CYCLES(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .fetch_go    (fetch_go),
    .pc_next     (pc_next),
    .pc_load     (pc_load),
    .pc_target   (pc_target),
    .mem         (bus),
    .busy        (busy),
    .instr_valid (instr_valid),
    .opcode      (opcode),
    .reg_a       (reg_a),
    .reg_b       (reg_b),
    .reg_c       (reg_c),
    .big_val     (big_val),
    .pc          (pc),
    .fetch_err   (fetch_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        go, nxt, ld;
    logic [7:0]  tgt;
    logic        ack;
    logic [15:0] rdata;
    logic        e_req;
    logic [7:0]  e_addr;
    logic        e_busy, e_valid;
    logic [15:0] e_ir;
    logic [7:0]  e_pc;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic req, input logic [7:0] addr,
                         input logic bsy, input logic vld, input logic [15:0] ir,
                         input logic [7:0] pcv, input logic err);
    chk({tag, ".req"},    {31'd0, bus.mem_req}, {31'd0, req});
    chk({tag, ".addr"},   {24'd0, bus.mem_addr}, {24'd0, addr});
    chk({tag, ".busy"},   {31'd0, busy}, {31'd0, bsy});
    chk({tag, ".valid"},  {31'd0, instr_valid}, {31'd0, vld});
    chk({tag, ".opcode"}, {28'd0, opcode}, {28'd0, ir[15:12]});
    chk({tag, ".reg_a"},  {28'd0, reg_a}, {28'd0, ir[11:8]});
    chk({tag, ".reg_b"},  {28'd0, reg_b}, {28'd0, ir[7:4]});
    chk({tag, ".reg_c"},  {28'd0, reg_c}, {28'd0, ir[3:0]});
    chk({tag, ".big"},    {24'd0, big_val}, {24'd0, ir[7:0]});
    chk({tag, ".pc"},     {24'd0, pc}, {24'd0, pcv});
    chk({tag, ".err"},    {31'd0, fetch_err}, {31'd0, err});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    fetch_go = 1'b0; pc_next = 1'b0; pc_load = 1'b0; pc_target = 8'h00;
    bus.mem_ack = 1'b0; bus.mem_rdata = 16'h0000;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //            go nxt ld tgt    ack rdata     | req addr   bsy vld ir        pc
    vecs.push_back('{0, 0, 0, 8'h00, 0, 16'h0000, 0, 8'h00, 0, 0, 16'h0000, 8'h00});
    vecs.push_back('{1, 0, 0, 8'h00, 0, 16'h0000, 1, 8'h00, 1, 0, 16'h0000, 8'h00});
    vecs.push_back('{0, 0, 0, 8'h00, 1, 16'h3A5C, 0, 8'h00, 0, 1, 16'h3A5C, 8'h00});
    vecs.push_back('{0, 0, 0, 8'h00, 1, 16'hFFFF, 0, 8'h00, 0, 1, 16'h3A5C, 8'h00});
    vecs.push_back('{0, 0, 1, 8'hFF, 0, 16'h0000, 0, 8'h00, 0, 1, 16'h3A5C, 8'hFF});
    vecs.push_back('{0, 1, 0, 8'h00, 0, 16'h0000, 0, 8'h00, 0, 1, 16'h3A5C, 8'h00});
    vecs.push_back('{0, 1, 1, 8'h40, 0, 16'h0000, 0, 8'h00, 0, 1, 16'h3A5C, 8'h40});
    vecs.push_back('{0, 0, 1, 8'h10, 0, 16'h0000, 0, 8'h00, 0, 1, 16'h3A5C, 8'h10});
    vecs.push_back('{1, 1, 0, 8'h00, 0, 16'h0000, 1, 8'h10, 1, 0, 16'h3A5C, 8'h11});
    vecs.push_back('{1, 0, 1, 8'h80, 0, 16'h0000, 1, 8'h10, 1, 0, 16'h3A5C, 8'h80});
    vecs.push_back('{1, 0, 0, 8'h00, 0, 16'h0000, 1, 8'h10, 1, 0, 16'h3A5C, 8'h80});
    vecs.push_back('{0, 0, 0, 8'h00, 1, 16'h1234, 0, 8'h10, 0, 1, 16'h1234, 8'h80});
    vecs.push_back('{0, 0, 0, 8'h00, 0, 16'h0000, 0, 8'h10, 0, 1, 16'h1234, 8'h80});
    vecs.push_back('{1, 0, 0, 8'h00, 0, 16'h0000, 1, 8'h80, 1, 0, 16'h1234, 8'h80});
    vecs.push_back('{0, 1, 0, 8'h00, 1, 16'hBEEF, 0, 8'h80, 0, 1, 16'hBEEF, 8'h81});
    vecs.push_back('{1, 0, 0, 8'h00, 1, 16'h7777, 1, 8'h81, 1, 0, 16'hBEEF, 8'h81});
    vecs.push_back('{0, 0, 0, 8'h00, 1, 16'h0F0F, 0, 8'h81, 0, 1, 16'h0F0F, 8'h81});

    reset = 1'b1;
    idle_inputs();
    #12;
    chk_all("reset", 0, 8'h00, 0, 0, 16'h0000, 8'h00, 0);
    @(posedge clk);
    #1 reset = 1'b0;

    foreach (vecs[i]) begin
      fetch_go      = vecs[i].go;
      pc_next       = vecs[i].nxt;
      pc_load       = vecs[i].ld;
      pc_target     = vecs[i].tgt;
      bus.mem_ack   = vecs[i].ack;
      bus.mem_rdata = vecs[i].rdata;
      step();
      chk_all($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_addr, vecs[i].e_busy,
              vecs[i].e_valid, vecs[i].e_ir, vecs[i].e_pc, 0);
    end

    // Stalled read: no ack for several cycles starting from pc=8'h81.
    idle_inputs();
    fetch_go = 1'b1;
    step();
    fetch_go = 1'b0;
    chk_all("stall.issue", 1, 8'h81, 1, 0, 16'h0F0F, 8'h81, 0);
    for (int k = 1; k <= 3; k++) begin
      step();
      chk_all($sformatf("stall.w%0d", k), 1, 8'h81, 1, 0, 16'h0F0F, 8'h81, 0);
    end
    step();
`ifdef FETCH_TIMEOUT_EN
    chk_all("stall.abort", 0, 8'h81, 0, 0, 16'h0F0F, 8'h81, 1);
    bus.mem_ack = 1'b1; bus.mem_rdata = 16'hDEAD;
    step();
    chk_all("stall.late_ack", 0, 8'h81, 0, 0, 16'h0F0F, 8'h81, 1);
    bus.mem_ack = 1'b0;
    fetch_go = 1'b1;
    step();
    fetch_go = 1'b0;
    chk_all("stall.retry", 1, 8'h81, 1, 0, 16'h0F0F, 8'h81, 0);
`else
    chk_all("stall.w4", 1, 8'h81, 1, 0, 16'h0F0F, 8'h81, 0);
    step();
    step();
    chk_all("stall.w6", 1, 8'h81, 1, 0, 16'h0F0F, 8'h81, 0);
`endif
    bus.mem_ack = 1'b1; bus.mem_rdata = 16'h5A96;
    step();
    bus.mem_ack = 1'b0;
    chk_all("stall.done", 0, 8'h81, 0, 1, 16'h5A96, 8'h81, 0);

    // Reset asserted mid-WAIT must drop the request before the next edge.
    fetch_go = 1'b1; pc_next = 1'b1;
    step();
    fetch_go = 1'b0; pc_next = 1'b0;
    chk_all("rstwait.pre", 1, 8'h81, 1, 0, 16'h5A96, 8'h82, 0);
    #2 reset = 1'b1;
    #1;
    chk_all("rstwait.async", 0, 8'h00, 0, 0, 16'h0000, 8'h00, 0);
    step();
    reset = 1'b0;
    chk_all("rstwait.held", 0, 8'h00, 0, 0, 16'h0000, 8'h00, 0);

    fetch_go = 1'b1;
    step();
    fetch_go = 1'b0;
    bus.mem_ack = 1'b1; bus.mem_rdata = 16'hC3E1;
    step();
    bus.mem_ack = 1'b0;
    chk_all("recover", 0, 8'h00, 0, 1, 16'hC3E1, 8'h00, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of the CPU control FSM.
- Owns the program counter and issues word reads to program memory over a req/ack handshake.
- Latches the returned word into an instruction register and presents decoded fields (opcode nibble, register fields, 8-bit immediate) to control.
- Accepts PC increment and PC load (jump/branch) commands from control.

Parameters:
- ADDR_WIDTH, 8, PC and memory address width.
- WORD_WIDTH, 16, instruction word width. Field layout below is fixed for 16.
- TIMEOUT_CYCLES, 15, maximum WAIT cycles before abort. Used only with FETCH_TIMEOUT_EN.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- fetch_go  input  1  control requests fetch at current PC; 1-cycle pulse.
- pc_next  input  1  PC <= PC + 1.
- pc_load  input  1  PC <= pc_target.
- pc_target  input  ADDR_WIDTH  jump/branch destination.
- mem_req  output  1  memory read request.
- mem_addr  output  ADDR_WIDTH  read address, stable while mem_req=1.
- mem_ack  input  1  memory data valid this cycle.
- mem_rdata  input  WORD_WIDTH  read data.
- busy  output  1  high while in WAIT.
- instr_valid  output  1  IR holds a freshly fetched word.
- opcode  output  4  IR[15:12].
- reg_a  output  4  IR[11:8].
- reg_b  output  4  IR[7:4].
- reg_c  output  4  IR[3:0].
- big_val  output  8  IR[7:0].
- pc  output  ADDR_WIDTH  current program counter.
- fetch_err  output  1  fetch aborted by timeout. Tied 0 without FETCH_TIMEOUT_EN.

Behaviour:
- Reset (async, immediate):
  - state=IDLE; pc=0; IR=0, so opcode=0 (NOP).
  - mem_req=0, mem_addr=0, busy=0, instr_valid=0, fetch_err=0, timeout counter=0.
- States: IDLE, WAIT. All outputs are registered except the decoded fields, which are combinational slices of IR.
- IDLE:
  - On fetch_go: mem_addr<=pc, mem_req<=1, busy<=1, instr_valid<=0, fetch_err<=0, go to WAIT.
  - Without fetch_go: hold.
- WAIT:
  - mem_req and mem_addr are held.
  - On mem_ack: IR<=mem_rdata, instr_valid<=1, mem_req<=0, busy<=0, go to IDLE.
  - fetch_go in WAIT is ignored (no queueing).
- Latency: fetch_go sampled at edge N; mem_req high after N. If mem_ack is high before edge N+k (k>=1), instr_valid and IR are valid after edge N+k. Minimum is 2 edges from fetch_go to valid.
- instr_valid stays high until the next accepted fetch_go. IR is held until overwritten.
- PC update (any state, evaluated every edge):
  - pc_load has priority over pc_next.
  - pc_next wraps from all-ones to 0.
  - PC changes during WAIT do not affect the outstanding mem_addr.
- fetch_go and pc_next/pc_load in the same IDLE cycle: the fetch uses the pre-update PC, and the PC updates on the same edge.
- mem_ack while IDLE (stray or late) is ignored; IR is unchanged.
- Reset during WAIT: the request is abandoned and mem_req drops immediately (asynchronously). Memory must tolerate a dropped request.

Optional Feature:
- Macro: FETCH_TIMEOUT_EN.
- Defined:
  - Counter clears on WAIT entry and increments each WAIT cycle without mem_ack.
  - When it reaches TIMEOUT_CYCLES without ack: mem_req<=0, busy<=0, fetch_err<=1, instr_valid stays 0, go to IDLE.
  - mem_ack on the same edge as expiry wins (normal completion).
  - fetch_err clears on the next accepted fetch_go or on reset.
- Undefined: no counter. WAIT lasts indefinitely until mem_ack; fetch_err is constant 0.

Test Plan:
- Reset then fetch_go with mem_ack one cycle after mem_req, mem_rdata=16'h3A5C -> mem_addr=0; after completion instr_valid=1, opcode=3, reg_a=A, reg_b=5, reg_c=C, big_val=8'h5C.
- pc=8'hFF, pulse pc_next -> pc=8'h00. pc_load=1 and pc_next=1 with pc_target=8'h40 -> pc=8'h40.
- fetch_go at pc=8'h10, then pc_load to 8'h80 during 3-cycle ack delay -> mem_addr stays 8'h10 throughout; IR gets the 8'h10 word; pc=8'h80.
- fetch_go repeated during WAIT, plus stray mem_ack in IDLE with rdata=16'hFFFF -> exactly one request; IR unchanged by the stray ack.
- Assert reset while in WAIT -> mem_req=0 and busy=0 before the next edge; all outputs at reset values.
- FETCH_TIMEOUT_EN, TIMEOUT_CYCLES=4, mem_ack never asserted -> mem_req drops after 4 WAIT cycles, fetch_err=1, instr_valid=0. Next fetch_go clears fetch_err.
